// File: rtl/orientation_pkg.sv
// Shared types and trig constants for the rover orientation search.
// Sine table is a quarter wave in 5-degree steps, Q1.16, rescaled on lookup.
package orientation_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHORTCUT,
    S_PTC,
    S_DELTAS,
    S_MOTION,
    S_SEARCH,
    S_REPORT
  } state_e;

  localparam int N_SUPPORTED = 3;
  localparam int SUPPORTED_SECTORS [N_SUPPORTED] = '{12, 24, 36};

  localparam int SIN_Q16 [19] = '{
    0, 5712, 11380, 16962, 22415, 27697, 32768,
    37590, 42126, 46341, 50203, 53684, 56756,
    59396, 61584, 63303, 64540, 65287, 65536
  };

  function automatic bit sector_supported(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < N_SUPPORTED; i++)
      if (SUPPORTED_SECTORS[i] == n) ok = 1'b1;
    return ok;
  endfunction

  // a is the angle in 5-degree units (0..71); result rounded to frac bits
  function automatic int trig_sin5(input int a, input int frac);
    int q;
    int r;
    int j;
    int m;
    q = a / 18;
    r = a % 18;
    j = (q % 2 == 0) ? r : 18 - r;
    m = SIN_Q16[j[4:0]];
    m = (m + (1 << (15 - frac))) >> (16 - frac);
    return (q >= 2) ? -m : m;
  endfunction

endpackage

// File: rtl/orientation_search_lut.sv
// Combinational sector -> (sin, cos) ROM, signed Q1.TRIG_FRAC.
// Indices outside the sector range read as zero.
module sector_trig_lut
  import orientation_pkg::*;
#(
  parameter int THETA_WIDTH = 5,
  parameter int NUM_SECTORS = 24,
  parameter int TRIG_FRAC   = 8
) (
  input  logic        [THETA_WIDTH-1:0] idx_i,
  output logic signed [TRIG_FRAC+1:0]   sin_o,
  output logic signed [TRIG_FRAC+1:0]   cos_o
);

  localparam int TW   = TRIG_FRAC + 2;
  localparam int STEP = 72 / NUM_SECTORS;

  if (!sector_supported(NUM_SECTORS)) begin : g_bad_sectors
    $error("sector_trig_lut: unsupported NUM_SECTORS %0d", NUM_SECTORS);
  end

  int a5;

  always_comb begin
    a5    = 0;
    sin_o = '0;
    cos_o = '0;
    if (int'(idx_i) < NUM_SECTORS) begin
      a5    = int'(idx_i) * STEP;
      sin_o = TW'(trig_sin5(a5, TRIG_FRAC));
      cos_o = TW'(trig_sin5((a5 + 18) % 72, TRIG_FRAC));
    end
  end

endmodule

// File: rtl/orientation_search.sv
// Heading of rover motion from two polar radar fixes, found by an
// iterative one-sector-per-cycle search with a stationary detector.
module orientation_search
  import orientation_pkg::*;
#(
  parameter int R_WIDTH      = 8,
  parameter int THETA_WIDTH  = 5,
  parameter int NUM_SECTORS  = 24,
  parameter int TRIG_FRAC    = 8,
  parameter int ERROR_FACTOR = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [R_WIDTH+THETA_WIDTH-1:0] r_theta_original,
  input  logic [R_WIDTH+THETA_WIDTH-1:0] r_theta_final,
  output logic                           busy,
  output logic                           done,
  output logic                           stationary,
  output logic [THETA_WIDTH-1:0]         orientation
);

  localparam int IW = R_WIDTH + THETA_WIDTH;
  localparam int TW = TRIG_FRAC + 2;
  localparam int XW = R_WIDTH + 2;
  localparam int DW = R_WIDTH + 3;
  localparam int PW = R_WIDTH + TRIG_FRAC + 5;
  localparam int MW = R_WIDTH + 1 + TW;
  localparam int OW = THETA_WIDTH + 1;

  state_e                  state_q;
  logic [R_WIDTH-1:0]      r_o_q, r_f_q;
  logic [THETA_WIDTH-1:0]  th_o_q, th_f_q;
  logic signed [XW-1:0]    x_o_q, y_o_q, x_f_q, y_f_q;
  logic signed [DW-1:0]    dx_q, dy_q;
  logic [THETA_WIDTH-1:0]  k_q, cand_q, res_or_q;
  logic [PW-1:0]           best_q;
  logic                    res_st_q;
  logic                    busy_q, done_q, stat_q;
  logic [THETA_WIDTH-1:0]  orient_q;

  logic signed [TW-1:0] s_o, c_o, s_f, c_f, s_k, c_k;

  sector_trig_lut #(
    .THETA_WIDTH(THETA_WIDTH),
    .NUM_SECTORS(NUM_SECTORS),
    .TRIG_FRAC  (TRIG_FRAC)
  ) u_lut_o (.idx_i(th_o_q), .sin_o(s_o), .cos_o(c_o));

  sector_trig_lut #(
    .THETA_WIDTH(THETA_WIDTH),
    .NUM_SECTORS(NUM_SECTORS),
    .TRIG_FRAC  (TRIG_FRAC)
  ) u_lut_f (.idx_i(th_f_q), .sin_o(s_f), .cos_o(c_f));

  sector_trig_lut #(
    .THETA_WIDTH(THETA_WIDTH),
    .NUM_SECTORS(NUM_SECTORS),
    .TRIG_FRAC  (TRIG_FRAC)
  ) u_lut_k (.idx_i(k_q), .sin_o(s_k), .cos_o(c_k));

  logic signed [MW-1:0] mx_o, my_o, mx_f, my_f;
  assign mx_o = MW'($signed({1'b0, r_o_q})) * MW'(c_o);
  assign my_o = MW'($signed({1'b0, r_o_q})) * MW'(s_o);
  assign mx_f = MW'($signed({1'b0, r_f_q})) * MW'(c_f);
  assign my_f = MW'($signed({1'b0, r_f_q})) * MW'(s_f);

  logic signed [DW-1:0] dx_w, dy_w;
  assign dx_w = DW'(x_f_q) - DW'(x_o_q);
  assign dy_w = DW'(y_f_q) - DW'(y_o_q);

  logic [DW-1:0] adx_w, ady_w;
  logic          small_w;
  assign adx_w   = dx_q[DW-1] ? -dx_q : dx_q;
  assign ady_w   = dy_q[DW-1] ? -dy_q : dy_q;
  assign small_w = (adx_w <= DW'(ERROR_FACTOR)) &&
                   (ady_w <= DW'(ERROR_FACTOR));

  // Single candidate per cycle: projection onto and off the k heading
  logic signed [PW-1:0] dot_w, crs_w;
  logic [PW-1:0]        acrs_w;
  logic                 upd_w, last_w;
  logic [THETA_WIDTH-1:0] cand_nxt;
  assign dot_w  = PW'(dx_q) * PW'(c_k) + PW'(dy_q) * PW'(s_k);
  assign crs_w  = PW'(dx_q) * PW'(s_k) - PW'(dy_q) * PW'(c_k);
  assign acrs_w = crs_w[PW-1] ? -crs_w : crs_w;
  assign upd_w  = !dot_w[PW-1] && (dot_w != '0) && (acrs_w < best_q);
  assign last_w = (k_q == THETA_WIDTH'(NUM_SECTORS - 1));
  assign cand_nxt = upd_w ? k_q : cand_q;

  logic [OW-1:0]          opp_sum;
  logic [THETA_WIDTH-1:0] opp_w;
  assign opp_sum = {1'b0, th_o_q} + OW'(NUM_SECTORS / 2);
  assign opp_w   = (opp_sum >= OW'(NUM_SECTORS)) ?
                   THETA_WIDTH'(opp_sum - OW'(NUM_SECTORS)) :
                   opp_sum[THETA_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      r_o_q    <= '0;
      r_f_q    <= '0;
      th_o_q   <= '0;
      th_f_q   <= '0;
      x_o_q    <= '0;
      y_o_q    <= '0;
      x_f_q    <= '0;
      y_f_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      k_q      <= '0;
      cand_q   <= '0;
      best_q   <= '0;
      res_or_q <= '0;
      res_st_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stat_q   <= 1'b0;
      orient_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            r_o_q   <= r_theta_original[R_WIDTH-1:0];
            th_o_q  <= r_theta_original[IW-1:R_WIDTH];
            r_f_q   <= r_theta_final[R_WIDTH-1:0];
            th_f_q  <= r_theta_final[IW-1:R_WIDTH];
            busy_q  <= 1'b1;
            state_q <= S_SHORTCUT;
          end
        end
        S_SHORTCUT: begin
          if (th_o_q == th_f_q) begin
            res_or_q <= (r_f_q >= r_o_q) ? th_o_q : opp_w;
            res_st_q <= 1'b0;
            state_q  <= S_REPORT;
          end else begin
            state_q  <= S_PTC;
          end
        end
        S_PTC: begin
          x_o_q   <= XW'(mx_o >>> TRIG_FRAC);
          y_o_q   <= XW'(my_o >>> TRIG_FRAC);
          x_f_q   <= XW'(mx_f >>> TRIG_FRAC);
          y_f_q   <= XW'(my_f >>> TRIG_FRAC);
          state_q <= S_DELTAS;
        end
        S_DELTAS: begin
          dx_q    <= dx_w;
          dy_q    <= dy_w;
          state_q <= S_MOTION;
        end
        S_MOTION: begin
          if (small_w) begin
            res_or_q <= orient_q;
            res_st_q <= 1'b1;
            state_q  <= S_REPORT;
          end else begin
            k_q     <= '0;
            cand_q  <= '0;
            best_q  <= '1;
            state_q <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (upd_w) begin
            best_q <= acrs_w;
            cand_q <= k_q;
          end
          if (last_w) begin
            res_or_q <= cand_nxt;
            res_st_q <= 1'b0;
            state_q  <= S_REPORT;
          end else begin
            k_q <= k_q + THETA_WIDTH'(1);
          end
        end
        S_REPORT: begin
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          orient_q <= res_or_q;
          stat_q   <= res_st_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign stationary  = stat_q;
  assign orientation = orient_q;

endmodule

// File: tb/tb_orientation_search.sv
// Scoreboard bench for orientation_search: real-valued trig reference
// model, 24-sector and 12-sector instances, handshake and reset cases.
module tb_orientation_search;

  localparam int RW = 8;
  localparam int TH = 5;
  localparam int FR = 8;
  localparam int EF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en24 = 1'b0;
  logic en12 = 1'b0;
  logic [RW+TH-1:0] ro24 = '0, rf24 = '0, ro12 = '0, rf12 = '0;
  logic busy24, done24, st24, busy12, done12, st12;
  logic [TH-1:0] or24, or12;

  always #5 clk = ~clk;

  orientation_search #(
    .R_WIDTH(RW), .THETA_WIDTH(TH), .NUM_SECTORS(24),
    .TRIG_FRAC(FR), .ERROR_FACTOR(EF)
  ) dut24 (
    .clock(clk), .reset(rst), .enable(en24),
    .r_theta_original(ro24), .r_theta_final(rf24),
    .busy(busy24), .done(done24),
    .stationary(st24), .orientation(or24)
  );

  orientation_search #(
    .R_WIDTH(RW), .THETA_WIDTH(TH), .NUM_SECTORS(12),
    .TRIG_FRAC(FR), .ERROR_FACTOR(EF)
  ) dut12 (
    .clock(clk), .reset(rst), .enable(en12),
    .r_theta_original(ro12), .r_theta_final(rf12),
    .busy(busy12), .done(done12),
    .stationary(st12), .orientation(or12)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int    orient;
    bit    stat;
    int    due;
    string tag;
  } exp_t;

  exp_t q24[$];
  exp_t q12[$];
  exp_t e24, e12;
  int mo24 = 0;
  int mo12 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int trig(input int k, input int n, input bit want_sin);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979 * k / n;
    v = want_sin ? $sin(ang) : $cos(ang);
    return int'(v * 256.0);
  endfunction

  function automatic void model(input int ro, input int to, input int rf,
                                input int tf, input int n, input int prev,
                                output int orient, output bit stat,
                                output int lat);
    int xo, yo, xf, yf, dx, dy, best, dot, cr;
    stat = 1'b0;
    orient = 0;
    if (to == tf) begin
      orient = (rf >= ro) ? to : (to + n / 2) % n;
      lat = 2;
      return;
    end
    xo = (ro * trig(to, n, 1'b0)) >>> FR;
    yo = (ro * trig(to, n, 1'b1)) >>> FR;
    xf = (rf * trig(tf, n, 1'b0)) >>> FR;
    yf = (rf * trig(tf, n, 1'b1)) >>> FR;
    dx = xf - xo;
    dy = yf - yo;
    if (iabs(dx) <= EF && iabs(dy) <= EF) begin
      stat = 1'b1;
      orient = prev;
      lat = 5;
      return;
    end
    best = 32'h7fffffff;
    for (int k = 0; k < n; k++) begin
      dot = dx * trig(k, n, 1'b0) + dy * trig(k, n, 1'b1);
      cr  = dx * trig(k, n, 1'b1) - dy * trig(k, n, 1'b0);
      if (dot > 0 && iabs(cr) < best) begin
        best = iabs(cr);
        orient = k;
      end
    end
    lat = n + 5;
  endfunction

  task automatic expect_job(input bit use12, input int ro, input int to,
                            input int rf, input int tf, input int acc,
                            input string tag);
    exp_t e;
    int o, lat;
    bit s;
    model(ro, to, rf, tf, use12 ? 12 : 24, use12 ? mo12 : mo24, o, s, lat);
    e.orient = o;
    e.stat = s;
    e.due = acc + lat;
    e.tag = tag;
    if (use12) begin
      mo12 = o;
      q12.push_back(e);
    end else begin
      mo24 = o;
      q24.push_back(e);
    end
  endtask

  task automatic drive(input bit use12, input int ro, input int to,
                       input int rf, input int tf, input bit en);
    if (use12) begin
      ro12 = {TH'(to), RW'(ro)};
      rf12 = {TH'(tf), RW'(rf)};
      en12 = en;
    end else begin
      ro24 = {TH'(to), RW'(ro)};
      rf24 = {TH'(tf), RW'(rf)};
      en24 = en;
    end
  endtask

  task automatic wait_idle(input bit use12);
    int t;
    t = 0;
    while ((use12 ? busy12 : busy24) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (use12 ? busy12 : busy24) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic issue(input bit use12, input int ro, input int to,
                       input int rf, input int tf, input string tag,
                       output int acc);
    wait_idle(use12);
    acc = cyc + 1;
    expect_job(use12, ro, to, rf, tf, acc, tag);
    drive(use12, ro, to, rf, tf, 1'b1);
    @(negedge clk);
    if (use12) en12 = 1'b0;
    else en24 = 1'b0;
  endtask

  task automatic rand_job(input bit use12, input string tag);
    int n, ro, to, rf, tf, mode, acc;
    n = use12 ? 12 : 24;
    ro = $urandom_range(0, 255);
    rf = $urandom_range(0, 255);
    to = $urandom_range(0, n - 1);
    tf = $urandom_range(0, n - 1);
    mode = $urandom_range(0, 3);
    if (mode == 0) tf = to;
    if (mode == 1) begin
      ro = $urandom_range(0, 6);
      rf = $urandom_range(0, 6);
    end
    issue(use12, ro, to, rf, tf, tag, acc);
  endtask

  always @(negedge clk) begin
    if (done24) begin
      if (q24.size() == 0) begin
        chk("done24_unexpected", 1, 0);
      end else begin
        e24 = q24.pop_front();
        chk({e24.tag, "_orient"}, int'(or24), e24.orient);
        chk({e24.tag, "_stat"}, int'(st24), int'(e24.stat));
        chk({e24.tag, "_done_edge"}, cyc, e24.due);
        chk({e24.tag, "_busy"}, int'(busy24), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done12) begin
      if (q12.size() == 0) begin
        chk("done12_unexpected", 1, 0);
      end else begin
        e12 = q12.pop_front();
        chk({e12.tag, "_orient"}, int'(or12), e12.orient);
        chk({e12.tag, "_stat"}, int'(st12), int'(e12.stat));
        chk({e12.tag, "_done_edge"}, cyc, e12.due);
        chk({e12.tag, "_busy"}, int'(busy12), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy24), 0);
    chk("rst_done", int'(done24), 0);
    chk("rst_orient", int'(or24), 0);
    chk("rst_stat", int'(st24), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 50, 3, 80, 3, "short_up", acc);
    issue(1'b0, 80, 3, 50, 3, "short_dn", acc);
    issue(1'b0, 100, 0, 100, 6, "diag", acc);
    issue(1'b0, 2, 0, 2, 1, "still", acc);

    // Ignored enable pulses, then enable held through done
    issue(1'b0, 60, 2, 120, 20, "hs_a", acc);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ro24 = (RW + TH)'($urandom);
      rf24 = (RW + TH)'($urandom);
      en24 = 1'b1;
      @(negedge clk);
    end
    en24 = 1'b0;
    wait_until(acc + 20);
    drive(1'b0, 100, 0, 100, 6, 1'b1);
    expect_job(1'b0, 100, 0, 100, 6, acc + 30, "hs_b");
    wait_until(acc + 30);
    en24 = 1'b0;

    for (int i = 0; i < 40; i++) rand_job(1'b0, $sformatf("r24_%0d", i));

    // Reset mid-search
    issue(1'b0, 100, 0, 100, 6, "rst_job", acc);
    wait_until(acc + 11);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy24), 0);
    chk("midrst_done", int'(done24), 0);
    chk("midrst_orient", int'(or24), 0);
    chk("midrst_stat", int'(st24), 0);
    rst = 1'b0;
    q24.delete();
    q12.delete();
    mo24 = 0;
    mo12 = 0;
    repeat (40) @(negedge clk);
    issue(1'b0, 2, 5, 2, 6, "post_rst", acc);

    issue(1'b1, 100, 0, 100, 6, "n12_diag", acc);
    for (int i = 0; i < 12; i++) rand_job(1'b1, $sformatf("r12_%0d", i));

    t = 0;
    while ((q24.size() != 0 || q12.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q24.size() + q12.size(), 0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
